alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
// - Multi-cycle, parametrised-width ALU for the datapath execute stage.
// - Keeps the single-cycle op set and encodings; adds XOR, SLTU, unsigned MUL (low half), DIVU and REMU.
// - MUL/DIV run on an iterative shift-add / restoring engine.
// - Operands enter and results leave over valid/ready handshakes, so the control FSM can stall on long ops.
// PARAMETERS
// - WIDTH  32  operand/result width in bits (>= 4)
// - SEL_W  4   op-select width (fixed encoding below)
// PORTS
// - clk        in   1      single clock; all state on rising edge
// - rst_n      in   1      synchronous, active-low reset (sampled on clk rising edge)
// - in_valid   in   1      operands + op valid
// - in_ready   out  1      block can accept an op
// - a_in       in   WIDTH  operand A
// - b_in       in   WIDTH  operand B
// - alu_sel    in   SEL_W  operation select
// - out_valid  out  1      result/flags valid
// - out_ready  in   1      consumer takes result
// - alu_out    out  WIDTH  registered result
// - carry_out  out  1      unsigned carry of ADD; 0 otherwise
// - overflow   out  1      signed overflow of ADD/SUB; 0 otherwise
// - zero       out  1      alu_out == 0
// BEHAVIOUR
// - Op encoding:
//   - 0000 AND, 0001 OR, 0010 ADD, 0011 SLTU, 0100 XOR, 0110 SUB, 0111 SLT
//   - 1000 MUL (low WIDTH bits), 1010 DIVU, 1011 REMU, 1100 NOR, 1111 EQ
//   - any other code: ADD with carry/overflow forced 0
// - Reset (rst_n=0 at edge):
//   - state=IDLE; in_ready=1 (asserts the cycle after reset); out_valid=0.
//   - alu_out=0, carry_out=0, overflow=0, zero=1.
//   - Overrides any op in flight, including mid-iteration; the partial result is discarded.
// - FSM IDLE/BUSY/DONE; in_ready = (state==IDLE).
//   - IDLE + in_valid, single-cycle op: compute and register result and flags; go to DONE. Latency 1.
//   - IDLE + in_valid, MUL/DIVU/REMU: latch operands; go to BUSY with iteration counter = WIDTH-1.
//   - BUSY: one multiplier/divider step per cycle; when counter==0, register result and go to DONE. Latency WIDTH+1.
//   - DONE: out_valid=1; outputs held stable while out_ready=0.
//   - DONE + out_ready: go to IDLE. No accept in the same cycle; peak throughput is 1 op / 2 cycles.
// - Inputs are ignored while in_ready=0, and in_valid is don't-care outside IDLE.
// - Arithmetic:
//   - ADD/SUB wrap modulo 2^WIDTH.
//   - carry = bit WIDTH of {0,A}+{0,B}.
//   - ADD overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
//   - SUB overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]); correct for B = most-negative value.
//   - SLT is signed, SLTU unsigned; SLT/SLTU/EQ return 1 or 0 zero-extended.
//   - MUL returns the low WIDTH bits of the unsigned product.
//   - zero is derived from the registered result, for every op.
// - Divide by zero (b_in==0):
//   - DIVU yields all-ones; REMU yields a_in. Still takes WIDTH+1 cycles.
//   - overflow=0 and carry=0.
// - Simultaneous events: rst_n=0 beats every handshake; out_ready with out_valid=0 has no effect.
// STRUCTURE
// - Package alu_mc_pkg: op-code localparams (OP_AND..OP_EQ), FSM state typedef/localparams.
// - Sub-module alu_mc_muldiv: iterative engine.
//   - Inputs: start, mode (mul/div), a, b.
//   - Outputs: busy, done, product_lo, quotient, remainder.
//   - WIDTH-step counter inside.
// - Top holds FSM, combinational single-cycle datapath, output/flag registers.
// TESTING (WIDTH=32)
// - Reset with in_valid=1 held: in_ready=1, out_valid=0, alu_out=0, zero=1; no op captured until rst_n=1.
// - ADD 0x7FFFFFFF+1: out_valid 1 cycle after accept; result 0x80000000, overflow=1, carry=0.
//   - ADD 0xFFFFFFFF+1: result 0, carry=1, zero=1.
// - SUB 0 - 0x80000000: result 0x80000000, overflow=1.
//   - SLT 0xFFFFFFFF,1: result 1. SLTU with the same operands: result 0.
// - MUL 12345*678: out_valid exactly 33 cycles after accept, alu_out=8369910.
//   - DIVU 100/7: result 14. REMU 100/7: result 2.
//   - DIVU x/0: result 0xFFFFFFFF. REMU 5/0: result 5.
// - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0.
//   - Then out_ready=1: IDLE next cycle; the next op is accepted.
// - Pull rst_n low 10 cycles into a DIVU: next cycle IDLE, out_valid never asserts.
//   - A fresh ADD 2+3 then returns 5.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared op codes and control states for the multi-cycle ALU.
package alu_mc_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             div_q;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] acc_n, mcand_n, mplier_n;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] tdiff;
  logic             ge;

  // acc is the partial product (mul) or partial remainder (div)
  always_comb begin
    trial    = {acc, mplier[WIDTH-1]};
    tdiff    = trial[WIDTH-1:0] - mcand;
    ge       = trial >= {1'b0, mcand};
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    if (div_q) begin
      acc_n    = ge ? tdiff : trial[WIDTH-1:0];
      mplier_n = {mplier[WIDTH-2:0], ge};
    end else begin
      acc_n    = mplier[0] ? acc + mcand : acc;
      mcand_n  = mcand << 1;
      mplier_n = mplier >> 1;
    end
  end

  assign done       = busy && (cnt == '0);
  assign product_lo = acc_n;
  assign quotient   = mplier_n;
  assign remainder  = acc_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      div_q  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= CW'(WIDTH - 1);
      div_q  <= mode;
      acc    <= '0;
      mcand  <= mode ? b : a;
      mplier <= mode ? a : b;
    end else if (busy) begin
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: handshake FSM, single-cycle datapath, result/flag registers.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [SEL_W-1:0] alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int M = WIDTH - 1;

  state_t           state, state_n;
  logic [SEL_W-1:0] op_q;
  logic             is_long, accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff, res, long_res;
  logic             c, v;
  logic             eng_busy, eng_done;
  logic [WIDTH-1:0] eng_prod, eng_quo, eng_rem;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign is_long   = (alu_sel == OP_MUL) || (alu_sel == OP_DIVU)
                  || (alu_sel == OP_REMU);
  assign accept    = in_ready && in_valid;

  always_comb begin
    sum  = {1'b0, a_in} + {1'b0, b_in};
    diff = a_in - b_in;
    res  = sum[WIDTH-1:0];
    c    = 1'b0;
    v    = 1'b0;
    unique case (alu_sel)
      OP_AND:  res = a_in & b_in;
      OP_OR:   res = a_in | b_in;
      OP_ADD: begin
        c = sum[WIDTH];
        v = (a_in[M] == b_in[M]) && (sum[M] != a_in[M]);
      end
      OP_SLTU: res = {{M{1'b0}}, a_in < b_in};
      OP_XOR:  res = a_in ^ b_in;
      OP_SUB: begin
        res = diff;
        v   = (a_in[M] != b_in[M]) && (diff[M] != a_in[M]);
      end
      OP_SLT:  res = {{M{1'b0}}, $signed(a_in) < $signed(b_in)};
      OP_NOR:  res = ~(a_in | b_in);
      OP_EQ:   res = {{M{1'b0}}, a_in == b_in};
      default: res = sum[WIDTH-1:0];
    endcase
  end

  assign long_res = (op_q == OP_MUL)  ? eng_prod :
                    (op_q == OP_REMU) ? eng_rem  : eng_quo;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (in_valid) state_n = is_long ? S_BUSY : S_DONE;
      S_BUSY: if (eng_busy && eng_done) state_n = S_DONE;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      alu_out   <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
    end else begin
      state <= state_n;
      if (accept) op_q <= alu_sel;
      if (accept && !is_long) begin
        alu_out   <= res;
        carry_out <= c;
        overflow  <= v;
        zero      <= (res == '0);
      end
      if (state == S_BUSY && eng_done) begin
        alu_out   <= long_res;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
        zero      <= (long_res == '0);
      end
    end
  end

  alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept && is_long),
    .mode       (alu_sel != OP_MUL),
    .a          (a_in),
    .b          (b_in),
    .busy       (eng_busy),
    .done       (eng_done),
    .product_lo (eng_prod),
    .quotient   (eng_quo),
    .remainder  (eng_rem)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Randomised bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_in, b_in;
  logic [3:0]    alu_sel;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_out;
  logic          carry_out, overflow, zero;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] sel,
                                input logic [31:0] a, b,
                                output logic [31:0] r,
                                output logic c, v);
    logic [63:0] u, p;
    longint sa, sb, ss;
    sa = $signed(a);
    sb = $signed(b);
    u  = {32'b0, a} + {32'b0, b};
    p  = {32'b0, a} * {32'b0, b};
    c  = 1'b0;
    v  = 1'b0;
    case (sel)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2: begin
        r  = a + b;
        c  = u[32];
        ss = sa + sb;
        v  = (ss > SMAX) || (ss < SMIN);
      end
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd6: begin
        r  = a - b;
        ss = sa - sb;
        v  = (ss > SMAX) || (ss < SMIN);
      end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  r = p[31:0];
      4'd10: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: r = (b == 0) ? a : a % b;
      4'd12: r = ~(a | b);
      4'd15: r = (a == b) ? 32'd1 : 32'd0;
      default: r = a + b;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, b,
                        input int hold, input string tag);
    logic [31:0] er;
    logic ec, ev;
    int lat, exp_lat;
    model(sel, a, b, er, ec, ev);
    exp_lat = (sel == 4'd8 || sel == 4'd10 || sel == 4'd11) ? W + 1 : 1;
    lat = 0;
    while (!in_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    alu_sel  = sel;
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        in_valid = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        alu_sel  = 4'($urandom);
      end
      lat++;
    end while (!out_valid && lat < 100);
    chk({tag, "/lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/res"}, 64'(alu_out), 64'(er));
    chk({tag, "/cy"}, 64'(carry_out), 64'(ec));
    chk({tag, "/ov"}, 64'(overflow), 64'(ev));
    chk({tag, "/z"}, 64'(zero), 64'(er == 0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "/hold_v"}, 64'(out_valid), 64'd1);
      chk({tag, "/hold_r"}, 64'(alu_out), 64'(er));
      chk({tag, "/hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "/rel_v"}, 64'(out_valid), 64'd0);
    chk({tag, "/rel_rdy"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corner [5];
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 15));
      1: return corner[$urandom_range(0, 4)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    alu_sel   = 4'd2;
    a_in      = 32'd5;
    b_in      = 32'd6;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/rdy", 64'(in_ready), 64'd1);
    chk("rst/v", 64'(out_valid), 64'd0);
    chk("rst/out", 64'(alu_out), 64'd0);
    chk("rst/z", 64'(zero), 64'd1);
    chk("rst/cy", 64'(carry_out), 64'd0);
    chk("rst/ov", 64'(overflow), 64'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst/v", 64'(out_valid), 64'd0);
    chk("post_rst/rdy", 64'(in_ready), 64'd1);

    run_op(4'd2, 32'h7FFF_FFFF, 32'h1, 0, "add_ovf");
    run_op(4'd2, 32'hFFFF_FFFF, 32'h1, 0, "add_cy");
    run_op(4'd6, 32'h0, 32'h8000_0000, 0, "sub_min");
    run_op(4'd7, 32'hFFFF_FFFF, 32'h1, 0, "slt");
    run_op(4'd3, 32'hFFFF_FFFF, 32'h1, 0, "sltu");
    run_op(4'd8, 32'd12345, 32'd678, 5, "mul");
    run_op(4'd10, 32'd100, 32'd7, 0, "divu");
    run_op(4'd11, 32'd100, 32'd7, 0, "remu");
    run_op(4'd10, 32'hDEAD_BEEF, 32'd0, 0, "divu0");
    run_op(4'd11, 32'd5, 32'd0, 0, "remu0");
    run_op(4'd5, 32'h7FFF_FFFF, 32'h1, 2, "dflt");

    in_valid = 1'b1;
    alu_sel  = 4'd10;
    a_in     = 32'd1000;
    b_in     = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort/rdy", 64'(in_ready), 64'd1);
    chk("abort/v", 64'(out_valid), 64'd0);
    chk("abort/out", 64'(alu_out), 64'd0);
    chk("abort/z", 64'(zero), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort/never_v", 64'(seen), 64'd0);
    run_op(4'd2, 32'd2, 32'd3, 0, "add_after");

    repeat (150) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(),
             $urandom_range(0, 3), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
